// File: rtl/act_pingpong_buffer_if.sv
// rtl/act_pingpong_buffer_if.sv - DMA write stream and consumer read port of the activation ping-pong buffer
interface act_pingpong_buffer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
);
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fill_done;
    logic              wr_ready;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              drain_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   rd_len;

    modport master (
        output wr_en, wr_addr, wr_data, fill_done, rd_en, rd_addr, drain_done,
        input  wr_ready, rd_data, rd_valid, rd_ready, rd_len
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, fill_done, rd_en, rd_addr, drain_done,
        output wr_ready, rd_data, rd_valid, rd_ready, rd_len
    );
endinterface

// File: rtl/act_pingpong_buffer.sv
// rtl/act_pingpong_buffer.sv - two-bank activation store with full/empty bank hand-over
module act_pingpong_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    act_pingpong_buffer_if.slave bus,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic [1:0]           bank_full,
    output logic                 err_ovf
);
    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [ADDR_W:0]   len [2];

    logic            in_range;
    logic            wr_accept;
    logic            fill_ok;
    logic            drain_ok;
    logic            rd_accept;
    logic            err_set;
    logic [ADDR_W:0] wr_len_cand;
    logic [1:0]      wr_oh;
    logic [1:0]      rd_oh;
    logic [1:0]      full_next;

    assign bus.wr_ready = !bank_full[wr_bank];
    assign bus.rd_ready = bank_full[rd_bank];
    assign bus.rd_len   = len[rd_bank];

    assign in_range    = (bus.wr_addr[31:ADDR_W] == '0);
    assign wr_accept   = bus.wr_en && bus.wr_ready && in_range;
    assign fill_ok     = bus.fill_done && bus.wr_ready;
    assign drain_ok    = bus.drain_done && bus.rd_ready;
    assign rd_accept   = bus.rd_en && bus.rd_ready;
    assign wr_len_cand = {1'b0, bus.wr_addr[ADDR_W-1:0]} + 1'b1;
    assign err_set     = (bus.wr_en && !(bus.wr_ready && in_range))
                       || (bus.fill_done && !bus.wr_ready)
                       || (bus.drain_done && !bus.rd_ready);

    // Both pulses are judged on pre-edge flags, so a same-cycle close and drain compose per bank.
    assign wr_oh     = {wr_bank, !wr_bank};
    assign rd_oh     = {rd_bank, !rd_bank};
    assign full_next = (bank_full | ({2{fill_ok}} & wr_oh)) & ~({2{drain_ok}} & rd_oh);

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept && !clear) begin
            mem[{wr_bank, bus.wr_addr[ADDR_W-1:0]}] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full    <= 2'b00;
            len[0]       <= '0;
            len[1]       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            err_ovf      <= 1'b0;
        end else if (clear) begin
            bank_full    <= 2'b00;
            len[0]       <= '0;
            len[1]       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bus.rd_valid <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            bank_full    <= full_next;
            bus.rd_valid <= rd_accept;
            if (rd_accept) begin
                bus.rd_data <= mem[{rd_bank, bus.rd_addr}];
            end
            // The read bank is full and the write bank is not, so these never hit the same len.
            if (drain_ok) begin
                len[rd_bank] <= '0;
            end
            if (wr_accept && (wr_len_cand > len[wr_bank])) begin
                len[wr_bank] <= wr_len_cand;
            end
            if (fill_ok) begin
                wr_bank <= !wr_bank;
            end
            if (drain_ok) begin
                rd_bank <= !rd_bank;
            end
            if (err_set) begin
                err_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_act_pingpong_buffer.sv
// tb/tb_act_pingpong_buffer.sv - directed self-checking bench for act_pingpong_buffer
module tb_act_pingpong_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] bank_full;
    logic       err_ovf;
    int         n_checks = 0;
    int         n_fail   = 0;

    act_pingpong_buffer_if #(.DATA_W(64), .ADDR_W(9)) bus ();

    act_pingpong_buffer #(.DATA_W(64), .DEPTH(512)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bus       (bus),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .bank_full (bank_full),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic fill();
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
    endtask

    task automatic drain();
        bus.drain_done = 1'b1;
        tick();
        bus.drain_done = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.fill_done = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.drain_done = 1'b0;
        tick(); tick();
        chk("rst_rd_data", bus.rd_data, 64'h0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_rd_len", bus.rd_len, 0);
        chk("rst_banks", {wr_bank, rd_bank}, 0);
        chk("rst_full", bank_full, 2'b00);
        chk("rst_err", err_ovf, 0);
        rst_n = 1'b1;
        tick();

        // single tile in bank 0
        for (int i = 0; i < 16; i++) wr(i, 64'(i));
        fill();
        chk("t1_rd_ready", bus.rd_ready, 1);
        chk("t1_rd_len", bus.rd_len, 16);
        chk("t1_wr_bank", wr_bank, 1);
        chk("t1_full", bank_full, 2'b01);
        chk("t1_rd_valid_idle", bus.rd_valid, 0);
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = 9'(i);
            tick();
            chk("t1_rd_valid", bus.rd_valid, 1);
            chk("t1_rd_data", bus.rd_data, 64'(i));
        end
        bus.rd_en = 1'b0;
        tick();
        chk("t1_rd_valid_off", bus.rd_valid, 0);

        // fill bank 1 while reading bank 0 in the same cycles
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = i; bus.wr_data = 64'(100 + i);
            bus.rd_en = 1'b1; bus.rd_addr = 9'(i);
            tick();
            chk("pp_rd_data", bus.rd_data, 64'(i));
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        fill();
        chk("pp_full", bank_full, 2'b11);
        chk("pp_wr_ready", bus.wr_ready, 0);
        chk("pp_rd_len_b0", bus.rd_len, 16);
        chk("pp_err_clean", err_ovf, 0);

        // both banks full: writes and extra fills are rejected
        wr(0, 64'hDEAD);
        chk("full_wr_err", err_ovf, 1);
        fill();
        chk("full_extra_fill", bank_full, 2'b11);
        chk("full_wr_bank", wr_bank, 0);
        rd(0);
        chk("full_b0_intact", bus.rd_data, 64'h0);
        drain();
        chk("pp_rd_bank", rd_bank, 1);
        chk("pp_rd_len_b1", bus.rd_len, 4);
        chk("pp_full_after", bank_full, 2'b10);
        chk("pp_wr_ready_after", bus.wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            rd(9'(i));
            chk("pp_b1_data", bus.rd_data, 64'(100 + i));
        end

        // clear mid-tile, with a concurrent write that clear overrides
        for (int i = 0; i < 5; i++) wr(i, 64'(200 + i));
        clear = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5; bus.wr_data = 64'h55;
        tick();
        clear = 1'b0; bus.wr_en = 1'b0;
        chk("clr_full", bank_full, 2'b00);
        chk("clr_banks", {wr_bank, rd_bank}, 0);
        chk("clr_err", err_ovf, 0);
        chk("clr_rd_len", bus.rd_len, 0);
        chk("clr_rd_valid", bus.rd_valid, 0);
        chk("clr_ready", {bus.wr_ready, bus.rd_ready}, 2'b10);

        // simultaneous fill_done and drain_done
        for (int i = 0; i < 3; i++) wr(i, 64'(300 + i));
        fill();
        chk("sim_len_b0", bus.rd_len, 3);
        for (int i = 0; i < 2; i++) wr(i, 64'(400 + i));
        bus.fill_done = 1'b1; bus.drain_done = 1'b1;
        tick();
        bus.fill_done = 1'b0; bus.drain_done = 1'b0;
        chk("sim_full", bank_full, 2'b10);
        chk("sim_wr_bank", wr_bank, 0);
        chk("sim_rd_bank", rd_bank, 1);
        chk("sim_err", err_ovf, 0);
        chk("sim_rd_len", bus.rd_len, 2);
        rd(1);
        chk("sim_b1_data", bus.rd_data, 64'(401));

        // out-of-range addresses
        do_clear();
        wr(512, 64'hBAD);
        chk("oor_512_err", err_ovf, 1);
        chk("oor_512_len", bus.rd_len, 0);
        wr(32'h8000_0000, 64'hBAD);
        chk("oor_hi_full", bank_full, 2'b00);
        wr(511, 64'h511);
        fill();
        chk("oor_511_len", bus.rd_len, 512);
        rd(0);
        chk("oor_b0_addr0", bus.rd_data, 64'(300));

        // drain on the same edge as an accepted read
        bus.rd_en = 1'b1; bus.rd_addr = 9'd511; bus.drain_done = 1'b1;
        tick();
        bus.rd_en = 1'b0; bus.drain_done = 1'b0;
        chk("dr_rd_valid", bus.rd_valid, 1);
        chk("dr_rd_data", bus.rd_data, 64'h511);
        chk("dr_full", bank_full, 2'b00);
        rd(5);
        chk("nr_rd_valid", bus.rd_valid, 0);
        chk("nr_rd_data_hold", bus.rd_data, 64'h511);
        do_clear();
        drain();
        chk("bad_drain_err", err_ovf, 1);
        chk("bad_drain_full", bank_full, 2'b00);

        // asynchronous reset mid-transfer
        do_clear();
        wr(0, 64'h77); wr(1, 64'h78);
        fill();
        bus.rd_en = 1'b1; bus.rd_addr = 9'd1;
        tick();
        chk("ar_rd_valid_pre", bus.rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd_valid", bus.rd_valid, 0);
        chk("ar_rd_data", bus.rd_data, 64'h0);
        chk("ar_full", bank_full, 2'b00);
        chk("ar_rd_len", bus.rd_len, 0);
        bus.rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(0, 64'h99);
        fill();
        chk("ar_next_len", bus.rd_len, 1);
        chk("ar_next_banks", {wr_bank, rd_bank, bank_full}, 4'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
